// File: rtl/target_model_pkg.sv
// Shared helpers for the memory-backed target model: parameter legality
// checks and the log2 used to size indices, pointers and counters.
package tgt_model_pkg;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit depth_legal(input int depth);
        return is_pow2(depth) && (depth >= 2);
    endfunction

    function automatic bit dw_legal(input int dw);
        return (dw >= 8) && ((dw % 8) == 0);
    endfunction

    function automatic bit latency_legal(input int latency);
        return latency >= 1;
    endfunction

    function automatic bit outst_legal(input int outst);
        return outst >= 1;
    endfunction

    // A single-entry queue still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/target_model_if.sv
// Target-side request/response handshake seen by a fabric target port.
interface target_model_if #(
    parameter int AW = 24,
    parameter int DW = 16
);

    logic            req_vld;
    logic            req_gnt;
    logic            req_wr;
    logic [DW/8-1:0] req_strb;
    logic [AW-1:0]   req_adr;
    logic [DW-1:0]   req_dat;
    logic            rsp_vld;
    logic            rsp_gnt;
    logic [DW-1:0]   rsp_dat;

    modport master (
        output req_vld, req_wr, req_strb, req_adr, req_dat, rsp_gnt,
        input  req_gnt, rsp_vld, rsp_dat
    );

    modport slave (
        input  req_vld, req_wr, req_strb, req_adr, req_dat, rsp_gnt,
        output req_gnt, rsp_vld, rsp_dat
    );

endinterface

// File: rtl/target_model_sync_fifo.sv
// Synchronous FIFO of arbitrary depth; head is visible on dout while not empty.
module sync_fifo
    import tgt_model_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entries are never read before being written, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/target_model.sv
// Memory-backed fabric target: byte-strobed writes, in-order responses after a
// fixed latency, with up to OUTST requests in flight.
module target_model
    import tgt_model_pkg::*;
#(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1,
    parameter int OUTST   = 2
) (
    input  logic           clk,
    input  logic           rstn,
    target_model_if.slave  bus
);

    localparam int SW = DW / 8;
    localparam int LW = clog2(SW);
    localparam int IW = clog2(DEPTH);
    localparam int CW = clog2(OUTST + 1);

    if (!(dw_legal(DW) && depth_legal(DEPTH) && latency_legal(LATENCY) &&
          outst_legal(OUTST) && (AW >= LW + IW))) begin : g_param_error
        $error("target_model: illegal parameter set");
    end

    logic [DW-1:0] mem [DEPTH];
    req_kind_e     req_kind;
    logic [IW-1:0] req_idx;
    logic          req_acc;
    logic          rsp_xfer;
    logic [DW-1:0] acc_dat;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          gnt_q;
    logic          push_vld;
    logic [DW-1:0] push_dat;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          unused_full;
    logic          unused_adr;

    assign req_kind   = req_kind_e'(bus.req_wr);
    assign req_idx    = bus.req_adr[LW +: IW];
    assign unused_adr = ^bus.req_adr;
    assign req_acc    = bus.req_vld && gnt_q;
    assign rsp_xfer   = !fifo_empty && bus.rsp_gnt;
    assign acc_dat    = (req_kind == REQ_WRITE) ? '0 : mem[req_idx];

    // A write landing on the reset edge is dropped along with everything else.
    always_ff @(posedge clk) begin
        if (rstn && req_acc && (req_kind == REQ_WRITE)) begin
            for (int i = 0; i < SW; i++) begin
                if (bus.req_strb[i]) begin
                    mem[req_idx][8*i +: 8] <= bus.req_dat[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        cnt_next = cnt;
        case ({req_acc, rsp_xfer})
            2'b10:   cnt_next = cnt + CW'(1);
            2'b01:   cnt_next = cnt - CW'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Credits cover the delay line as well as the queue, so the queue never overflows.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt   <= '0;
            gnt_q <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            gnt_q <= (cnt_next < CW'(OUTST));
        end
    end

    if (LATENCY == 1) begin : g_no_delay
        assign push_vld = req_acc;
        assign push_dat = acc_dat;
    end else begin : g_delay
        localparam int NS = LATENCY - 1;

        logic          chain_vld [NS+1];
        logic [DW-1:0] chain_dat [NS+1];

        assign chain_vld[0] = req_acc;
        assign chain_dat[0] = acc_dat;

        for (genvar s = 0; s < NS; s++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    chain_vld[s+1] <= 1'b0;
                    chain_dat[s+1] <= '0;
                end else begin
                    chain_vld[s+1] <= chain_vld[s];
                    chain_dat[s+1] <= chain_dat[s];
                end
            end
        end

        assign push_vld = chain_vld[NS];
        assign push_dat = chain_dat[NS];
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (OUTST)
    ) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_vld),
        .pop   (rsp_xfer),
        .din   (push_dat),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (unused_full)
    );

    assign bus.req_gnt = gnt_q;
    assign bus.rsp_vld = !fifo_empty;
    assign bus.rsp_dat = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_target_model.sv
// Bench for target_model: three parameter sets driven side by side and checked
// every cycle against a byte-array / response-queue reference model.
module tb_target_model;

    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        drv_vld  [NDUT];
    logic        drv_wr   [NDUT];
    logic        drv_rgnt [NDUT];
    logic [3:0]  drv_strb [NDUT];
    logic [23:0] drv_adr  [NDUT];
    logic [31:0] drv_dat  [NDUT];
    logic        obs_gnt  [NDUT];
    logic        obs_vld  [NDUT];
    logic [31:0] obs_dat  [NDUT];

    target_model_if #(.AW(AW), .DW(DW)) bus0 ();
    target_model_if #(.AW(AW), .DW(DW)) bus1 ();
    target_model_if #(.AW(AW), .DW(DW)) bus2 ();

    assign bus0.req_vld = drv_vld[0];  assign bus1.req_vld = drv_vld[1];  assign bus2.req_vld = drv_vld[2];
    assign bus0.req_wr  = drv_wr[0];   assign bus1.req_wr  = drv_wr[1];   assign bus2.req_wr  = drv_wr[2];
    assign bus0.req_strb = drv_strb[0]; assign bus1.req_strb = drv_strb[1]; assign bus2.req_strb = drv_strb[2];
    assign bus0.req_adr = drv_adr[0];  assign bus1.req_adr = drv_adr[1];  assign bus2.req_adr = drv_adr[2];
    assign bus0.req_dat = drv_dat[0];  assign bus1.req_dat = drv_dat[1];  assign bus2.req_dat = drv_dat[2];
    assign bus0.rsp_gnt = drv_rgnt[0]; assign bus1.rsp_gnt = drv_rgnt[1]; assign bus2.rsp_gnt = drv_rgnt[2];
    assign obs_gnt[0] = bus0.req_gnt;  assign obs_gnt[1] = bus1.req_gnt;  assign obs_gnt[2] = bus2.req_gnt;
    assign obs_vld[0] = bus0.rsp_vld;  assign obs_vld[1] = bus1.rsp_vld;  assign obs_vld[2] = bus2.rsp_vld;
    assign obs_dat[0] = bus0.rsp_dat;  assign obs_dat[1] = bus1.rsp_dat;  assign obs_dat[2] = bus2.rsp_dat;

    target_model #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(1), .OUTST(2))
        dut_a (.clk(clk), .rstn(rstn), .bus(bus0));
    target_model #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(3), .OUTST(2))
        dut_b (.clk(clk), .rstn(rstn), .bus(bus1));
    target_model #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LATENCY(2), .OUTST(3))
        dut_c (.clk(clk), .rstn(rstn), .bus(bus2));

    // Reference state: byte memory, response queue with ready cycle, credits.
    logic [7:0]  ref_mem [NDUT][DEPTH*4];
    logic [31:0] rq_dat  [NDUT][16];
    int          rq_rdy  [NDUT][16];
    int          rq_head [NDUT];
    int          rq_tail [NDUT];
    int          ref_cnt [NDUT];
    bit          ref_gnt [NDUT];
    int          cyc;
    int          vectors;
    int          miscompares;

    typedef struct {
        bit          wr;
        logic [3:0]  strb;
        logic [23:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int outst_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int word_index(input logic [23:0] adr);
        return int'((adr / 24'd4) % 24'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_word(input int d, input int idx);
        return {ref_mem[d][idx*4+3], ref_mem[d][idx*4+2], ref_mem[d][idx*4+1], ref_mem[d][idx*4]};
    endfunction

    function automatic bit ref_vld(input int d);
        return (rq_head[d] != rq_tail[d]) && (rq_rdy[d][rq_head[d] % 16] <= cyc);
    endfunction

    task automatic check_val(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic check_output();
        for (int d = 0; d < NDUT; d++) begin
            check_val("req_gnt", d, 32'(obs_gnt[d]), 32'(ref_gnt[d]));
            check_val("rsp_vld", d, 32'(obs_vld[d]), 32'(ref_vld(d)));
            if (ref_vld(d)) begin
                check_val("rsp_dat", d, obs_dat[d], rq_dat[d][rq_head[d] % 16]);
            end
        end
    endtask

    task automatic model_edge(input int d);
        bit acc;
        bit xfer;
        int idx;
        if (!rstn) begin
            rq_head[d] = rq_tail[d];
            ref_cnt[d] = 0;
            ref_gnt[d] = 1'b1;
            return;
        end
        acc  = drv_vld[d] && ref_gnt[d];
        xfer = ref_vld(d) && drv_rgnt[d];
        if (xfer) rq_head[d]++;
        if (acc) begin
            idx = word_index(drv_adr[d]);
            if (drv_wr[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (drv_strb[d][b]) ref_mem[d][idx*4+b] = drv_dat[d][8*b +: 8];
                end
                rq_dat[d][rq_tail[d] % 16] = 32'h0;
            end else begin
                rq_dat[d][rq_tail[d] % 16] = ref_word(d, idx);
            end
            rq_rdy[d][rq_tail[d] % 16] = cyc + lat_of(d);
            rq_tail[d]++;
        end
        ref_cnt[d] = ref_cnt[d] + int'(acc) - int'(xfer);
        ref_gnt[d] = (ref_cnt[d] < outst_of(d));
    endtask

    task automatic tick();
        for (int d = 0; d < NDUT; d++) model_edge(d);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_output();
    endtask

    task automatic apply_stimulus(input int d, input bit vld, input bit wr, input logic [3:0] strb,
                                  input logic [23:0] adr, input logic [31:0] dat);
        drv_vld[d]  = vld;
        drv_wr[d]   = wr;
        drv_strb[d] = strb;
        drv_adr[d]  = adr;
        drv_dat[d]  = dat;
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            apply_stimulus(d, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
            drv_rgnt[d] = 1'b1;
        end
    endtask

    // Holds a request until the DUT grants it, within a cycle budget.
    task automatic send(input int d, input bit wr, input logic [3:0] strb,
                        input logic [23:0] adr, input logic [31:0] dat);
        bit accepted;
        accepted = 1'b0;
        apply_stimulus(d, 1'b1, wr, strb, adr, dat);
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = obs_gnt[d];
            tick();
        end
        drv_vld[d] = 1'b0;
        check_val("send_accepted", d, 32'(accepted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_word [8];
        logic [31:0] got [2];
        logic [31:0] pre_word;
        int          nresp;
        bit          acc3;
        bit          seen;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rstn        = 1'b0;
        idle_all();
        for (int d = 0; d < NDUT; d++) begin
            rq_head[d] = 0;
            rq_tail[d] = 0;
            ref_cnt[d] = 0;
            ref_gnt[d] = 1'b1;
        end

        tick();
        tick();
        for (int d = 0; d < NDUT; d++) begin
            check_val("reset_gnt", d, 32'(obs_gnt[d]), 32'd1);
            check_val("reset_vld", d, 32'(obs_vld[d]), 32'd0);
            check_val("reset_dat", d, obs_dat[d], 32'd0);
        end
        rstn = 1'b1;
        tick();

        // Give every word a known value before anything reads it.
        for (int d = 0; d < NDUT; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                send(d, 1'b1, 4'hF, 24'(w * 4), 32'h01010101 * 32'(w + 1));
            end
        end
        repeat (6) tick();

        tbl[0] = '{1'b1, 4'hF, 24'h000008, 32'hDEADBEEF, 32'h00000000};
        tbl[1] = '{1'b0, 4'h0, 24'h000008, 32'h00000000, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 4'h3, 24'h000008, 32'h00001122, 32'h00000000};
        tbl[3] = '{1'b0, 4'h0, 24'h000008, 32'h00000000, 32'hDEAD1122};
        tbl[4] = '{1'b1, 4'hF, 24'h000004, 32'h00000055, 32'h00000000};
        tbl[5] = '{1'b0, 4'h0, 24'h100004, 32'h00000000, 32'h00000055};
        tbl[6] = '{1'b1, 4'h8, 24'h00000B, 32'hAB123456, 32'h00000000};
        tbl[7] = '{1'b0, 4'h0, 24'hFFFF0A, 32'h00000000, 32'hABAD1122};
        tbl[8] = '{1'b1, 4'h0, 24'h000004, 32'hFFFFFFFF, 32'h00000000};
        tbl[9] = '{1'b0, 4'h0, 24'h000007, 32'h00000000, 32'h00000055};

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 1'b1, tbl[i].wr, tbl[i].strb, tbl[i].adr, tbl[i].dat);
            check_val("tbl_gnt", 0, 32'(obs_gnt[0]), 32'd1);
            tick();
            drv_vld[0] = 1'b0;
            check_val("tbl_rsp_vld", 0, 32'(obs_vld[0]), 32'd1);
            check_val("tbl_rsp_dat", 0, obs_dat[0], tbl[i].exp);
        end
        repeat (3) tick();

        // Back-pressure on the LATENCY=3, OUTST=2 instance.
        drv_rgnt[1] = 1'b0;
        exp_word[0] = ref_word(1, 0);
        exp_word[1] = ref_word(1, 1);
        apply_stimulus(1, 1'b1, 1'b0, 4'h0, 24'h000000, 32'h0);
        check_val("bp_gnt_first", 1, 32'(obs_gnt[1]), 32'd1);
        tick();
        apply_stimulus(1, 1'b1, 1'b0, 4'h0, 24'h000004, 32'h0);
        check_val("bp_gnt_second", 1, 32'(obs_gnt[1]), 32'd1);
        tick();
        apply_stimulus(1, 1'b1, 1'b0, 4'h0, 24'h000008, 32'h0);
        check_val("bp_gnt_drop", 1, 32'(obs_gnt[1]), 32'd0);
        repeat (5) tick();
        check_val("bp_gnt_held", 1, 32'(obs_gnt[1]), 32'd0);
        check_val("bp_head_vld", 1, 32'(obs_vld[1]), 32'd1);
        check_val("bp_head_dat", 1, obs_dat[1], exp_word[0]);
        drv_rgnt[1] = 1'b1;
        nresp = 0;
        acc3  = 1'b0;
        got[0] = '0;
        got[1] = '0;
        for (int i = 0; i < 20; i++) begin
            if (obs_vld[1]) begin
                if (nresp < 2) got[nresp] = obs_dat[1];
                nresp++;
            end
            if (obs_gnt[1] && !acc3) begin
                acc3 = 1'b1;
                tick();
                drv_vld[1] = 1'b0;
            end else begin
                tick();
            end
        end
        check_val("bp_resp0", 1, got[0], exp_word[0]);
        check_val("bp_resp1", 1, got[1], exp_word[1]);
        check_val("bp_third_accepted", 1, 32'(acc3), 32'd1);
        check_val("bp_resp_count", 1, 32'(nresp), 32'd3);

        // Streaming on the LATENCY=2, OUTST=3 instance.
        for (int i = 0; i < 8; i++) exp_word[i] = ref_word(2, i % DEPTH);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                apply_stimulus(2, 1'b1, 1'b0, 4'h0, 24'(j * 4), 32'h0);
                check_val("st_gnt", 2, 32'(obs_gnt[2]), 32'd1);
            end else begin
                drv_vld[2] = 1'b0;
            end
            if (j >= 2) begin
                check_val("st_rsp_vld", 2, 32'(obs_vld[2]), 32'd1);
                check_val("st_rsp_dat", 2, obs_dat[2], exp_word[j-2]);
            end
            tick();
        end
        repeat (4) tick();

        // Reset with responses queued and a write in the reset cycle.
        for (int d = 0; d < NDUT; d++) drv_rgnt[d] = 1'b0;
        pre_word = ref_word(2, 0);
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < NDUT; d++) apply_stimulus(d, 1'b1, 1'b0, 4'h0, 24'(k * 4), 32'h0);
            tick();
        end
        for (int d = 0; d < NDUT; d++) drv_vld[d] = 1'b0;
        check_val("rst_pre_queued", 0, 32'(obs_vld[0]), 32'd1);
        rstn = 1'b0;
        apply_stimulus(2, 1'b1, 1'b1, 4'hF, 24'h000000, 32'hCAFEF00D);
        tick();
        rstn = 1'b1;
        idle_all();
        for (int d = 0; d < NDUT; d++) begin
            check_val("rst_vld", d, 32'(obs_vld[d]), 32'd0);
            check_val("rst_gnt", d, 32'(obs_gnt[d]), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            for (int d = 0; d < NDUT; d++) check_val("rst_stale", d, 32'(obs_vld[d]), 32'd0);
        end
        send(2, 1'b0, 4'h0, 24'h000000, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (obs_vld[2]) begin
                seen = 1'b1;
                check_val("rst_write_dropped", 2, obs_dat[2], pre_word);
            end
            tick();
        end
        check_val("rst_read_seen", 2, 32'(seen), 32'd1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rstn = ($urandom_range(0, 99) != 0);
            for (int d = 0; d < NDUT; d++) begin
                apply_stimulus(d, ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                               4'($urandom_range(0, 15)), 24'($urandom), $urandom);
                drv_rgnt[d] = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        rstn = 1'b1;
        idle_all();
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
